// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-to-read bypass and busy scoreboard
// Ports: clk/rst (sync, active-high); we/waddr/wdata write-back ports;
// re/raddr read ports -> rdata/rvalid (combinational); rsv_en/rsv_addr reservation
// ports; busy registered scoreboard (bit 0 hardwired low). Register 0 reads as zero.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WR-1:0]          we,
    input  logic [NUM_WR*ADDR_W-1:0]   waddr,
    input  logic [NUM_WR*DATA_W-1:0]   wdata,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rvalid,
    input  logic [NUM_WR-1:0]          rsv_en,
    input  logic [NUM_WR*ADDR_W-1:0]   rsv_addr,
    output logic [2**ADDR_W-1:0]       busy
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_nxt;
    // Write-backs clear first, reservations set afterwards so a new producer wins.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NUM_WR; i++)
            if (we[i]) busy_nxt[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
        for (int i = 0; i < NUM_WR; i++)
            if (rsv_en[i]) busy_nxt[rsv_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
        busy_nxt[0] = 1'b0;
    end
    // Ascending loop with non-blocking writes: the highest-indexed port wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) regs[a] <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++)
                if (we[i] && waddr[i*ADDR_W +: ADDR_W] != '0)
                    regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
            busy <= busy_nxt;
        end
    end
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;
        logic [DATA_W-1:0] bdata;
        assign ra = raddr[j*ADDR_W +: ADDR_W];
        always_comb begin
            hit   = 1'b0;
            bdata = '0;
            for (int i = 0; i < NUM_WR; i++)
                if (we[i] && waddr[i*ADDR_W +: ADDR_W] == ra) begin
                    hit   = 1'b1;
                    bdata = wdata[i*DATA_W +: DATA_W];
                end
        end
        assign rdata[j*DATA_W +: DATA_W] = (rst || !re[j] || ra == '0) ? '0 : hit ? bdata : regs[ra];
        assign rvalid[j] = !rst && re[j] && (ra == '0 || hit || !busy[ra]);
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table plus randomized run against an array-based reference model
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NW = 2;
    logic             clk = 1'b0;
    logic             rst;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rvalid;
    logic [NW-1:0]    rsv_en;
    logic [NW*AW-1:0] rsv_addr;
    logic [31:0]      busy;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    typedef struct packed {
        logic              r;
        logic [1:0]        we;
        logic [1:0][4:0]   wa;
        logic [1:0][31:0]  wd;
        logic [1:0]        rs;
        logic [1:0][4:0]   sa;
        logic [3:0]        re;
        logic [3:0][4:0]   ra;
        logic [31:0]       xd0;
        logic [3:0]        xv;
        logic [31:0]       xb;
    } vec_t;
    vec_t vq[$];
    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask
    function automatic void add(logic r, logic [1:0] w, logic [4:0] wa0, logic [4:0] wa1,
                                logic [31:0] wd0, logic [31:0] wd1, logic [1:0] rs,
                                logic [4:0] sa0, logic [4:0] sa1, logic [3:0] e, logic [19:0] ra,
                                logic [31:0] xd0, logic [3:0] xv, logic [31:0] xb);
        vec_t v;
        v.r = r; v.we = w; v.wa = {wa1, wa0}; v.wd = {wd1, wd0}; v.rs = rs; v.sa = {sa1, sa0};
        v.re = e; v.ra = ra; v.xd0 = xd0; v.xv = xv; v.xb = xb;
        vq.push_back(v);
    endfunction
    // Reference: read-port priority rules evaluated directly on the model arrays.
    task automatic model_check();
        logic [NR*DW-1:0] xd;
        logic [NR-1:0]    xv;
        logic [31:0]      xb;
        xd = '0;
        xv = '0;
        for (int j = 0; j < NR; j++) begin
            int a;
            int h;
            a = int'(raddr[j*AW +: AW]);
            h = -1;
            for (int i = 0; i < NW; i++)
                if (we[i] && int'(waddr[i*AW +: AW]) == a) h = i;
            if (rst || !re[j]) begin
                xd[j*DW +: DW] = '0; xv[j] = 1'b0;
            end else if (a == 0) begin
                xd[j*DW +: DW] = '0; xv[j] = 1'b1;
            end else if (h >= 0) begin
                xd[j*DW +: DW] = wdata[h*DW +: DW]; xv[j] = 1'b1;
            end else begin
                xd[j*DW +: DW] = m_regs[a]; xv[j] = !m_busy[a];
            end
        end
        for (int a = 0; a < 32; a++) xb[a] = m_busy[a];
        check("model_rdata", 128'(rdata), 128'(xd));
        check("model_rvalid", 128'(rvalid), 128'(xv));
        check("model_busy", 128'(busy), 128'(xb));
    endtask
    task automatic model_update();
        bit nb [32];
        for (int a = 0; a < 32; a++) begin
            bit r, w;
            r = 0; w = 0;
            for (int i = 0; i < NW; i++) begin
                if (rsv_en[i] && int'(rsv_addr[i*AW +: AW]) == a) r = 1;
                if (we[i] && int'(waddr[i*AW +: AW]) == a) w = 1;
            end
            nb[a] = (a == 0) ? 1'b0 : r ? 1'b1 : w ? 1'b0 : m_busy[a];
        end
        if (rst) begin
            for (int a = 0; a < 32; a++) begin m_regs[a] = '0; m_busy[a] = 0; end
        end else begin
            for (int i = 0; i < NW; i++)
                if (we[i] && waddr[i*AW +: AW] != '0) m_regs[waddr[i*AW +: AW]] = wdata[i*DW +: DW];
            for (int a = 0; a < 32; a++) m_busy[a] = nb[a];
        end
    endtask
    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask
    initial begin
        rst = 1'b1; we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0; rsv_en = '0; rsv_addr = '0;
        @(posedge clk);
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin m_regs[a] = '0; m_busy[a] = 0; end
        add(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4'hF, {5'd31, 5'd3, 5'd2, 5'd1}, 0, 4'h0, 0);
        add(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4'hF, {5'd31, 5'd3, 5'd2, 5'd1}, 0, 4'hF, 0);
        add(0, 2'b11, 5, 5, 32'hAAAA0000, 32'h5555FFFF, 2'b00, 0, 0, 4'h1, 20'd5, 32'h5555FFFF, 4'h1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4'h1, 20'd5, 32'h5555FFFF, 4'h1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 2'b01, 7, 0, 4'h1, 20'd7, 0, 4'h1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4'h1, 20'd7, 0, 4'h0, 32'h80);
        add(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4'h1, 20'd7, 0, 4'h0, 32'h80);
        add(0, 2'b01, 7, 0, 32'h12345678, 0, 2'b00, 0, 0, 4'h1, 20'd7, 32'h12345678, 4'h1, 32'h80);
        add(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4'h1, 20'd7, 32'h12345678, 4'h1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 2'b01, 9, 0, 4'h1, 20'd9, 0, 4'h1, 0);
        add(0, 2'b01, 9, 0, 32'h1, 0, 2'b10, 0, 9, 4'h1, 20'd9, 32'h1, 4'h1, 32'h200);
        add(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4'h1, 20'd9, 32'h1, 4'h0, 32'h200);
        add(0, 2'b01, 0, 0, 32'hFFFFFFFF, 0, 2'b01, 0, 0, 4'h1, 20'd0, 0, 4'h1, 32'h200);
        add(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4'h1, 20'd0, 0, 4'h1, 32'h200);
        add(0, 2'b00, 0, 0, 0, 0, 2'b11, 3, 4, 4'h0, 20'd0, 0, 4'h0, 32'h200);
        add(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4'hF, {5'd7, 5'd9, 5'd4, 5'd3}, 0, 4'h0, 32'h218);
        add(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4'hF, {5'd7, 5'd9, 5'd4, 5'd3}, 0, 4'hF, 0);
        add(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 4'h5, {5'd7, 5'd9, 5'd4, 5'd3}, 0, 4'h5, 0);
        foreach (vq[k]) begin
            rst = vq[k].r; we = vq[k].we; waddr = vq[k].wa; wdata = vq[k].wd;
            rsv_en = vq[k].rs; rsv_addr = vq[k].sa; re = vq[k].re; raddr = vq[k].ra;
            #1;
            check($sformatf("vec%0d_rdata", k), 128'(rdata), {96'b0, vq[k].xd0});
            check($sformatf("vec%0d_rvalid", k), 128'(rvalid), 128'(vq[k].xv));
            check($sformatf("vec%0d_busy", k), 128'(busy), 128'(vq[k].xb));
            step();
        end
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            we = NW'($urandom);
            rsv_en = NW'($urandom);
            re = NR'($urandom);
            for (int i = 0; i < NW; i++) begin
                waddr[i*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
                rsv_addr[i*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
                wdata[i*DW +: DW] = $urandom;
            end
            for (int j = 0; j < NR; j++)
                raddr[j*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the dual-issue pipeline. It replaces the single-write, two-read register file in the decode stage. It provides NUM_RD combinational read ports, NUM_WR write-back ports with same-cycle write-to-read bypass, and a per-register busy scoreboard. Issue logic uses the scoreboard to stall on operands that are still in flight. Register 0 reads as zero and is never written or reserved.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width; depth = 2**ADDR_W.
- NUM_RD, 4: number of read ports (1..8).
- NUM_WR, 2: number of write ports and reservation ports (1..4).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  NUM_WR  write enable, one bit per write port.
- waddr  in  NUM_WR*ADDR_W  write addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_WR*DATA_W  write data, packed the same way.
- re  in  NUM_RD  read enable per read port.
- raddr  in  NUM_RD*ADDR_W  read addresses, packed.
- rdata  out  NUM_RD*DATA_W  read data, packed; combinational.
- rvalid  out  NUM_RD  operand-ready flag per read port; combinational.
- rsv_en  in  NUM_WR  reservation request: mark destination busy (issued, not yet written back).
- rsv_addr  in  NUM_WR*ADDR_W  reservation addresses, packed.
- busy  out  2**ADDR_W  registered scoreboard vector; bit 0 is always 0.

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits, plus a busy bit per register.
- Write: at each edge, for every port i with we[i]=1 and waddr[i]!=0, regs[waddr[i]] <= wdata[i].
  - Two ports writing the same address in the same cycle: the highest-indexed port wins.
- Read port j, priority in order:
  - rst=1 -> rdata=0, rvalid=0.
  - re[j]=0 -> rdata=0, rvalid=0.
  - raddr[j]=0 -> rdata=0, rvalid=1.
  - Bypass hit (some i with we[i]=1 and waddr[i]==raddr[j]) -> rdata = wdata of the highest-indexed hitting port, rvalid=1.
  - Otherwise -> rdata = regs[raddr[j]], rvalid = ~busy[raddr[j]].
- Scoreboard, evaluated per address a at each edge:
  - next busy[a] = 1 if any rsv_en[i] with rsv_addr[i]==a.
  - Otherwise 0 if any we[i] with waddr[i]==a.
  - Otherwise the current busy[a].
  - A reservation in the same cycle as a write to the same address wins: the new producer supersedes the old one. The data is still written.
  - Reservation or write to address 0 is ignored; busy[0] is hardwired to 0.
  - Re-reserving an already-busy register is legal; busy stays 1.
- Writes to non-busy registers are legal and update data; busy stays 0.

## Timing
- Read latency 0 cycles: combinational from raddr, re, we, waddr, wdata and registered state.
- Write visible through bypass in the same cycle; visible from storage from the next cycle.
- Reservation is visible on busy and rvalid from the cycle after rsv_en.
- Write-back clears busy at the edge; rvalid is already 1 in the write cycle via bypass.
- Reset, synchronous:
  - At the first edge with rst=1, all registers are cleared to 0 and all busy bits to 0.
  - While rst=1: rdata=0, rvalid=0, and we/rsv_en are ignored.
  - Reset mid-operation discards pending reservations; in-flight write-backs arriving after reset still write but find busy=0.
- No internal multicycle state beyond the register array and the busy vector. Multiple ports may target one register in the same cycle per the priority rules above.

## Test plan
- Reset then read: assert rst 1 cycle, set re=all, raddr0..3=1,2,3,31 -> rdata all 0x00000000, rvalid all 1, busy=0.
- Dual write collision: we=2'b11, waddr0=waddr1=5, wdata0=0xAAAA0000, wdata1=0x5555FFFF.
  - Same cycle: read r5 returns 0x5555FFFF (bypass).
  - Next cycle with we=0: read r5 returns 0x5555FFFF.
- Scoreboard life cycle:
  - Cycle 0: rsv_en0 on r7. Cycle 1: busy[7]=1; read r7 gives rvalid=0.
  - Cycle 3: we0 to r7 with 0x12345678 -> same cycle rvalid=1, rdata=0x12345678. Cycle 4: busy[7]=0.
- Reserve-vs-write race: r9 busy; in one cycle we0 writes r9=0x1 and rsv_en1 reserves r9 -> next cycle busy[9]=1, stored r9=0x1, read rvalid=0.
- Register zero: we0 writes r0=0xFFFFFFFF and rsv_en0 reserves r0 -> read r0 gives 0/rvalid=1; busy[0]=0 always.
- Reset mid-flight: reserve r3 and r4, assert rst 1 cycle -> busy=0 and regs zero. A subsequent read of r3 gives 0 with rvalid=1. re=0 on any port gives rdata=0, rvalid=0.
